apu_mixer: RTL and testbench
============================

# apu_mixer

Stereo mixing and decimation stage between the APU channel generators and the codec serializer. It pans the four 4-bit channel levels into left and right sums using NR51, applies the NR50 master volume, and box-car averages over a fixed window of `clockgb` cycles. Each finished stereo sample is queued into a 2-entry buffer and handed downstream on a valid/ready handshake.

## Interface
- `DECIM`, default 91: window length in `clockgb` cycles; one stereo sample per window. 91 gives about 44 kHz from 4 MHz. Legal range 2..136.
- `clockgb` input 1: system/GB clock; all state on its rising edge.
- `resetn` input 1: reset, asynchronous assert, active-low.
- `ch1`, `ch2`, `ch3`, `ch4` input 4 each: instantaneous channel levels, 0..15.
- `nr50` input 8: master volume. [6:4] is left, [2:0] is right. Bits 7 and 3 (Vin) are ignored.
- `nr51` input 8: panning. [7:4] routes ch4..ch1 to left; [3:0] routes ch4..ch1 to right.
- `enable` input 1: NR52[7]. When low, all channel inputs are treated as 0.
- `clear_overrun` input 1: synchronous clear of `overrun`.
- `sample_left` output 16: unsigned left sample at the buffer head.
- `sample_right` output 16: unsigned right sample at the buffer head.
- `sample_valid` output 1: the buffer is non-empty.
- `sample_ready` input 1: downstream accepts the head sample on a clock edge where valid and ready are both high.
- `overrun` output 1: sticky flag; set when a finished sample is dropped because the buffer is full.

## Operation
- **Per-cycle contribution, left side:**
  - sumL = sum over channels i with nr51[3+i] set of ch_i. Range 0..60, 6 bits.
  - L = sumL × (nr50[6:4]+1). Range 0..480, 9 bits.
- **Per-cycle contribution, right side:** same form, using nr51[i-1] and nr50[2:0]+1.
- **Input sampling:** `ch*`, `nr50`, `nr51` and `enable` are sampled every cycle. A mid-window change affects only that cycle onward.
- **Window counter:** `win` counts 0..DECIM-1 and wraps.
- **Accumulators:** accL and accR are each ACC_W = clog2(480·DECIM+1) bits, which is 16 for the default. They add L and R every cycle.
- **Window end (win == DECIM-1):**
  - The finished sums are accL+L and accR+R.
  - The accumulators load 0 for the next window.
  - The finished pair is pushed into the buffer. Each value saturates at 0xFFFF if ACC_W > 16 and is zero-extended if ACC_W < 16.
- **Buffer:**
  - 2 entries, strictly in order.
  - Push while full: the sample is dropped, `overrun` is set, and buffer contents are unchanged.
  - Push and pop in the same cycle while full: the pop is taken first, the push is accepted, and the buffer stays full with no overrun.
  - Push and pop in the same cycle with one entry: the count stays at 1 and the head becomes the new sample.
  - No fall-through: a sample pushed into an empty buffer becomes visible on the next cycle.
- **`overrun`:**
  - Cleared by `clear_overrun`.
  - If a set and a clear occur in the same cycle, set wins.
- **Outputs when empty:** `sample_left` and `sample_right` hold their last value and are only meaningful while `sample_valid` is high.

## Timing
- **Reset values:** `win`=0, accL=accR=0, buffer empty, `sample_valid`=0, `sample_left`=`sample_right`=0, `overrun`=0.
- **Reset mid-window:** the partial sums are discarded. The first window after release is a full DECIM cycles.
- **Latency:** the input on the last window cycle appears in the sample output one cycle later, with `sample_valid` rising on that edge.
- **Throughput:** one sample per DECIM cycles. Downstream must pop within about 2·DECIM cycles to avoid overrun.
- **Handshake stability:** `sample_valid` and the head data stay stable until popped. Ready may toggle freely; there is no combinational path from ready to valid.

## Structure
- **`apu_pkg`:** channel count 4, volume/pan field positions, MAX_LEVEL=15, `function acc_width(decim)`.
- **Sub-module `apu_sample_fifo`:** 2-entry, 32-bit-wide synchronous FIFO with push, pop, full, empty and drop-on-full reporting. The mixer top owns the pan, volume, window and accumulate logic.

## Test plan
All scenarios use DECIM=4.
1. **Reset:** hold resetn=0 with arbitrary inputs; then release with all channels 0. Required: all outputs 0. After 4 cycles, valid=1 with left=right=0.
2. **Constant mix:** enable=1, ch1=15, others 0, nr51=0x11, nr50=0x77, ready=1. Required: left=right=480 valid every 4th cycle, each for exactly 1 cycle.
3. **Panning and volume:** ch1=15, ch2=10, nr51=0x21, nr50=0x30. Required: left=10·4·4=160, right=15·1·4=60.
4. **Overrun:** constant mix as scenario 2, ready=0 for 3 windows.
   - Required: valid=1 with a 2-entry buffer, and overrun=1 at the third window end.
   - Then set ready=1. Required: exactly 2 pops, each 480, in order.
   - Then pulse clear_overrun. Required: overrun=0.
5. **Enable and mid-window change:** enable=0 gives a sample of 0/0. Switching ch1 from 0 to 15 after 2 cycles of a window gives 240/240.
6. **Reset mid-window and simultaneous push/pop:**
   - Assert resetn=0 at win=2. Required: the next sample covers a full fresh window.
   - With the buffer full, pop on the push cycle. Required: overrun stays 0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and types for the APU stereo mixer and its output buffer.
package apu_pkg;

  localparam int NUM_CH    = 4;
  localparam int MAX_LEVEL = 15;
  localparam int LEVEL_W   = 4;

  // Volume fields of NR50: [6:4] left, [2:0] right.
  localparam int VOL_L_LSB = 4;
  localparam int VOL_R_LSB = 0;
  localparam int VOL_W     = 3;

  // Pan fields of NR51: [7:4] ch4..ch1 to left, [3:0] ch4..ch1 to right.
  localparam int PAN_L_LSB = 4;
  localparam int PAN_R_LSB = 0;

  // Pan sum of four channels (0..60) and that sum times a gain of 1..8 (0..480).
  localparam int SUM_W   = 6;
  localparam int MIX_W   = 9;
  localparam int MAX_MIX = NUM_CH * MAX_LEVEL * 8;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  // Accumulator width that holds a full window of maximum contributions.
  function automatic int acc_width(input int decim);
    return $clog2(MAX_MIX * decim + 1);
  endfunction

endpackage

// File: rtl/apu_sample_fifo.sv
// Two-entry in-order stereo sample buffer. Slot 0 is always the head and is
// registered, so a sample pushed into an empty buffer shows up one cycle later
// and the head holds its last value once the buffer drains.
module apu_sample_fifo
  import apu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  stereo_t push_data,
  input  logic    pop,        // pop request; ignored while empty
  output stereo_t head_data,
  output logic    full,
  output logic    empty,
  output logic    drop        // push refused because the buffer stayed full
);

  logic [1:0] count_q, count_d;
  stereo_t    slot0_q, slot0_d;
  stereo_t    slot1_q, slot1_d;
  logic       pop_ok;

  // Next-state: a pop is serviced before a push, so full + pop + push is accepted.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    pop_ok  = pop && (count_q != 2'd0);
    drop    = push && (count_q == 2'd2) && !pop_ok;
    case (count_q)
      2'd0: begin
        if (push) begin
          slot0_d = push_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop_ok) begin
          slot0_d = push_data;
        end else if (push) begin
          slot1_d = push_data;
          count_d = 2'd2;
        end else if (pop_ok) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop_ok) begin
          slot0_d = slot1_q;
          if (push) begin
            slot1_d = push_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign head_data = slot0_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/apu_mixer.sv
// Stereo pan/volume mixer with box-car decimation over DECIM cycles. Each
// finished window sum is queued into a two-entry buffer for the serializer.
module apu_mixer
  import apu_pkg::*;
#(
  parameter int DECIM = 91
) (
  input  logic                clockgb,
  input  logic                resetn,
  input  logic [LEVEL_W-1:0]  ch1,
  input  logic [LEVEL_W-1:0]  ch2,
  input  logic [LEVEL_W-1:0]  ch3,
  input  logic [LEVEL_W-1:0]  ch4,
  input  logic [7:0]          nr50,
  input  logic [7:0]          nr51,
  input  logic                enable,
  input  logic                clear_overrun,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);

  localparam int ACC_W = acc_width(DECIM);
  localparam int WIN_W = $clog2(DECIM);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DECIM - 1);

  logic [LEVEL_W-1:0] ch_arr [NUM_CH];
  logic [LEVEL_W-1:0] term_l [NUM_CH];
  logic [LEVEL_W-1:0] term_r [NUM_CH];
  logic [SUM_W-1:0]   sum_l, sum_r;
  logic [3:0]         gain_l, gain_r;
  logic [MIX_W-1:0]   mix_l, mix_r;
  logic [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [ACC_W-1:0]   fin_l, fin_r;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               win_end;
  logic               overrun_q, overrun_d;
  stereo_t            push_pair, head_pair;
  logic               fifo_full, fifo_empty, fifo_drop;

  assign ch_arr[0] = ch1;
  assign ch_arr[1] = ch2;
  assign ch_arr[2] = ch3;
  assign ch_arr[3] = ch4;

  // Per-channel pan gating; a disabled APU contributes silence.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pan
    assign term_l[gi] = (enable && nr51[PAN_L_LSB + gi]) ? ch_arr[gi] : '0;
    assign term_r[gi] = (enable && nr51[PAN_R_LSB + gi]) ? ch_arr[gi] : '0;
  end

  assign gain_l = {1'b0, nr50[VOL_L_LSB +: VOL_W]} + 4'd1;
  assign gain_r = {1'b0, nr50[VOL_R_LSB +: VOL_W]} + 4'd1;

  // Pan sums and master volume for this cycle's contribution.
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_l = sum_l + SUM_W'(term_l[i]);
      sum_r = sum_r + SUM_W'(term_r[i]);
    end
    mix_l = MIX_W'(sum_l) * MIX_W'(gain_l);
    mix_r = MIX_W'(sum_r) * MIX_W'(gain_r);
  end

  // Window counter and accumulators; the last cycle of a window completes the sum.
  always_comb begin
    win_end = (win_q == WIN_LAST);
    fin_l   = acc_l_q + ACC_W'(mix_l);
    fin_r   = acc_r_q + ACC_W'(mix_r);
    if (win_end) begin
      win_d   = '0;
      acc_l_d = '0;
      acc_r_d = '0;
    end else begin
      win_d   = win_q + WIN_W'(1);
      acc_l_d = fin_l;
      acc_r_d = fin_r;
    end
  end

  // Fit the window sum into a 16-bit sample (saturate only if it can exceed it).
  if (ACC_W > SAMPLE_W) begin : g_sat
    assign push_pair.left  = (|fin_l[ACC_W-1:SAMPLE_W]) ? '1 : fin_l[SAMPLE_W-1:0];
    assign push_pair.right = (|fin_r[ACC_W-1:SAMPLE_W]) ? '1 : fin_r[SAMPLE_W-1:0];
  end else begin : g_ext
    assign push_pair.left  = SAMPLE_W'(fin_l);
    assign push_pair.right = SAMPLE_W'(fin_r);
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (fifo_drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Mixer state registers.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      win_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      overrun_q <= overrun_d;
    end
  end

  apu_sample_fifo u_fifo (
    .clk       (clockgb),
    .rst_n     (resetn),
    .push      (win_end),
    .push_data (push_pair),
    .pop       (sample_ready),
    .head_data (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign sample_left  = head_pair.left;
  assign sample_right = head_pair.right;
  assign sample_valid = !fifo_empty;
  assign overrun      = overrun_q;

  // Vin bits of NR50 and the full flag are intentionally not used here.
  logic unused_ok;
  assign unused_ok = ^{nr50[7], nr50[3], fifo_full};

endmodule

// File: tb/tb_apu_mixer.sv
// Scoreboard bench for apu_mixer with DECIM=4.
module tb_apu_mixer;

  localparam int D = 4;

  logic        clockgb = 1'b0;
  logic        resetn;
  logic [3:0]  ch1, ch2, ch3, ch4;
  logic [7:0]  nr50, nr51;
  logic        enable, clear_overrun, sample_ready;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, overrun;

  always #5 clockgb = ~clockgb;

  apu_mixer #(.DECIM(D)) dut (
    .clockgb       (clockgb),
    .resetn        (resetn),
    .ch1           (ch1),
    .ch2           (ch2),
    .ch3           (ch3),
    .ch4           (ch4),
    .nr50          (nr50),
    .nr51          (nr51),
    .enable        (enable),
    .clear_overrun (clear_overrun),
    .sample_left   (sample_left),
    .sample_right  (sample_right),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun)
  );

  typedef struct {
    int l;
    int r;
  } pair_t;

  pair_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_win, m_acc_l, m_acc_r;
  bit    m_ovr;
  int    pops = 0;
  int    last_l, last_r;
  int    p0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference contribution of the current inputs to one side.
  function automatic int mix(input bit left);
    int s;
    int g;
    logic [3:0] lv [4];
    lv[0] = ch1; lv[1] = ch2; lv[2] = ch3; lv[3] = ch4;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if (enable && nr51[(left ? 4 : 0) + i]) s += int'(lv[i]);
    end
    g = left ? int'(nr50[6:4]) + 1 : int'(nr50[2:0]) + 1;
    return s * g;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_win   = 0;
    m_acc_l = 0;
    m_acc_r = 0;
    m_ovr   = 0;
  endtask

  // One clock: score any pop at this edge, advance the model, then check state.
  task automatic tick();
    bit    pop_now;
    bit    dropped;
    pair_t p;
    pair_t e;
    pop_now = sample_valid && sample_ready;
    dropped = 0;
    if (pop_now) begin
      check_eq("sb_depth", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("pop_left", int'(sample_left), e.l);
        check_eq("pop_right", int'(sample_right), e.r);
        last_l = int'(sample_left);
        last_r = int'(sample_right);
        pops++;
      end
    end
    m_acc_l += mix(1'b1);
    m_acc_r += mix(1'b0);
    if (m_win == D - 1) begin
      p.l = m_acc_l;
      p.r = m_acc_r;
      if (exp_q.size() < 2) exp_q.push_back(p);
      else dropped = 1;
      m_acc_l = 0;
      m_acc_r = 0;
      m_win   = 0;
    end else begin
      m_win++;
    end
    if (dropped) m_ovr = 1;
    else if (clear_overrun) m_ovr = 0;
    @(posedge clockgb);
    #1;
    $display("t=%0t win=%0d valid=%0b L=%0d R=%0d ovr=%0b", $time, m_win,
             sample_valid, sample_left, sample_right, overrun);
    check_eq("valid", int'(sample_valid), int'(exp_q.size() != 0));
    check_eq("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic align();
    for (int i = 0; i < D && m_win != 0; i++) tick();
    check_eq("align", m_win, 0);
  endtask

  task automatic set_const_mix();
    enable = 1; ch1 = 15; ch2 = 0; ch3 = 0; ch4 = 0;
    nr51 = 8'h11; nr50 = 8'h77;
  endtask

  initial begin
    // 1. reset with arbitrary inputs
    resetn = 0; clear_overrun = 0; sample_ready = 1;
    enable = 1; ch1 = 7; ch2 = 3; ch3 = 9; ch4 = 1; nr50 = 8'h77; nr51 = 8'hFF;
    model_reset();
    repeat (3) @(posedge clockgb);
    #1;
    check_eq("rst_valid", int'(sample_valid), 0);
    check_eq("rst_left", int'(sample_left), 0);
    check_eq("rst_right", int'(sample_right), 0);
    check_eq("rst_ovr", int'(overrun), 0);
    ch1 = 0; ch2 = 0; ch3 = 0; ch4 = 0;
    resetn = 1;
    repeat (4) tick();
    check_eq("rst_first_valid", int'(sample_valid), 1);
    check_eq("rst_first_left", int'(sample_left), 0);
    check_eq("rst_first_right", int'(sample_right), 0);

    // 2. constant mix, ready held high
    set_const_mix();
    p0 = pops;
    repeat (12) tick();
    check_eq("const_pops", pops - p0, 3);
    check_eq("const_left", last_l, 480);
    check_eq("const_right", last_r, 480);

    // 3. panning and volume
    ch2 = 10; nr51 = 8'h21; nr50 = 8'h30;
    repeat (8) tick();
    check_eq("pan_left", last_l, 160);
    check_eq("pan_right", last_r, 60);

    // 4. overrun with ready low for three windows
    set_const_mix();
    tick();
    sample_ready = 0;
    repeat (11) tick();
    check_eq("ovr_valid", int'(sample_valid), 1);
    check_eq("ovr_flag", int'(overrun), 1);
    check_eq("ovr_depth", exp_q.size(), 2);
    sample_ready = 1;
    p0 = pops;
    repeat (2) tick();
    check_eq("ovr_pops", pops - p0, 2);
    check_eq("ovr_pop_left", last_l, 480);
    check_eq("ovr_sticky", int'(overrun), 1);
    clear_overrun = 1;
    tick();
    clear_overrun = 0;
    check_eq("ovr_cleared", int'(overrun), 0);

    // 5. enable low, then mid-window channel change
    align();
    enable = 0;
    repeat (4) tick();
    enable = 1; ch1 = 0;
    repeat (2) tick();
    check_eq("dis_left", last_l, 0);
    check_eq("dis_right", last_r, 0);
    ch1 = 15;
    repeat (3) tick();
    check_eq("mid_left", last_l, 240);
    check_eq("mid_right", last_r, 240);

    // 6a. reset at win=2
    align();
    repeat (2) tick();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clockgb);
    #1;
    check_eq("mid_rst_valid", int'(sample_valid), 0);
    resetn = 1;
    p0 = pops;
    repeat (5) tick();
    check_eq("mid_rst_pops", pops - p0, 1);
    check_eq("mid_rst_left", last_l, 480);

    // 6b. simultaneous push and pop while full
    sample_ready = 0;
    for (int i = 0; i < 3 * D && exp_q.size() < 2; i++) tick();
    check_eq("full_depth", exp_q.size(), 2);
    for (int i = 0; i < D && m_win != D - 1; i++) tick();
    sample_ready = 1;
    tick();
    sample_ready = 0;
    check_eq("pp_ovr", int'(overrun), 0);
    check_eq("pp_valid", int'(sample_valid), 1);
    check_eq("pp_depth", exp_q.size(), 2);
    sample_ready = 1;
    p0 = pops;
    repeat (2) tick();
    check_eq("pp_drain", pops - p0, 2);
    check_eq("pp_left", last_l, 480);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
